vc_crossbar3_router: RTL and testbench
======================================

Name: vc_crossbar3_router

Overview:
- 3-input, 3-output val/rdy packet router; the flow-controlled, self-arbitrating counterpart of the combinational 3x3 mux crossbar.
- Each input carries a message plus a 2-bit destination port.
- A per-output round-robin arbiter drives the output mux select internally, so upstream logic never computes select signals.
- Each output has a one-entry buffer; routing latency is 1 cycle. Used between cache banks and processor ports.

Parameters:
- p_nbits, 32, message payload width in bits.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- inK_msg (K=0..2)  input  p_nbits  input K payload.
- inK_dest (K=0..2)  input  2  input K destination; 0..2 valid, 3 invalid.
- inK_val (K=0..2)  input  1  input K valid.
- inK_rdy (K=0..2)  output  1  input K ready; transfer when val&&rdy.
- outJ_msg (J=0..2)  output  p_nbits  output J payload (buffer contents).
- outJ_val (J=0..2)  output  1  output J buffer full.
- outJ_rdy (J=0..2)  input  1  downstream ready; dequeue when val&&rdy.

Behaviour:
- Reset (clk edge with reset=1):
  - all outJ_val=0; buffer payloads don't-care.
  - all arbiter pointers set to input 0 highest priority.
  - inK_rdy=0 while reset is high.
- Request: input K requests output J iff inK_val && inK_dest==J. Each input requests at most one output, so there is no cross-arbiter conflict.
- Output J can accept when !outJ_val || outJ_rdy. Same-cycle dequeue and enqueue are allowed, giving full throughput of 1 msg/cycle/output.
- Arbitration:
  - Arbiter J grants one requester, rotating priority starting at pointer ptrJ.
  - Grant is a function of val/dest/pointer only, never of inK_rdy, so there is no combinational loop.
- inK_rdy = grant(K) && accept(dest(K)), or inK_val && inK_dest==3.
- Combinational path outJ_rdy -> inK_rdy exists and is documented for integrators.
- Transfer: on a granted transfer to J, the buffer loads inK_msg and outJ_val=1 next cycle. Latency is exactly 1 cycle from input handshake to outJ_val.
- Pointer update: ptrJ becomes (granted K + 1) mod 3 only on a cycle where the transfer occurs. When output J is blocked, ptrJ and the grant hold, so a blocked winner keeps its grant.
- Dequeue with no enqueue: outJ_val=0 next cycle.
- dest==3: the message is consumed (rdy=1) and discarded. No output changes and no pointer changes.
- Simultaneous events:
  - Distinct destinations: all transfers happen in the same cycle, e.g. a full permutation moves 3 msgs/cycle.
  - Same destination: one transfer per cycle.
- Reset mid-operation: buffered messages are dropped, with no partial output.
- No reordering within an input-output pair.
- Starvation bound: a waiting request is granted within 3 accepting cycles of its output.

Optional Feature:
- Macro: VC_CROSSBAR3_ROUTER_DOMAIN_EN.
- Defined:
  - Adds ports cur_sd (input, 1) and inK_sd (input, 1, K=0..2).
  - Input K may request only when inK_sd==cur_sd. A mismatched input sees rdy=0, and that includes dest==3.
  - Arbiter pointers are kept separately per domain (2 sets), so one domain's traffic never perturbs the other's arbitration order.
- Undefined: no sd ports; a single pointer set; behaviour as above.

Decomposition:
- Shared package, vc_crossbar_pkg:
  - constants c_nports=3, c_dest_nbits=2, c_dest_drop=2'd3.
  - typedef for the dest field.
- Sub-module vc_rr_arb3: 3-bit request, 3-bit one-hot grant, with an internal priority pointer that advances on an enable input.
- Instantiated once per output, or twice per output under the domain macro.
- The top level holds the request decode, three vc_rr_arb3 instances, the grant-driven output muxes and the output buffers.

Test Plan:
- Reset then idle: all outJ_val=0 and inK_rdy=0 during reset. Then in0 msg 0xA5 dest 2 -> out2_val=1, out2_msg=0xA5 next cycle, with out0/out1 invalid.
- Contention: all inputs val, dest=1, out1_rdy=1 held -> accepts in order in0,in1,in2,in0, one per cycle. out1_msg follows the same order.
- Backpressure: out1 full and out1_rdy=0 with in0,in2 requesting 1 -> both inK_rdy=0 and the grant holds on in0. Raise out1_rdy -> in0 accepted that cycle, in2 next.
- Permutation: in0->1, in1->2, in2->0 with msgs 1,2,3 in one cycle -> all three rdy=1, and next cycle out0=3, out1=1, out2=2.
- Drop and reset: in1 dest=3 msg 0x77 -> in1_rdy=1 and no outJ_val rises. Then fill all buffers and assert reset -> all outJ_val=0 next cycle, and ptr returns to in0.
- Domain (macro on): cur_sd=0, in0_sd=1, in1_sd=0, both to dest 0 -> only in1 accepted and in0_rdy=0. Flip cur_sd=1 -> in0 accepted.

Source files
------------

// File: rtl/vc_crossbar_pkg.sv
// rtl/vc_crossbar_pkg.sv - shared constants, dest type and port-index helper for the 3x3 val/rdy router
package vc_crossbar_pkg;

  localparam int c_nports     = 3;
  localparam int c_dest_nbits = 2;

  typedef logic [c_dest_nbits-1:0] dest_t;

  localparam dest_t c_dest_drop = 2'd3;

  function automatic logic [1:0] next_port(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/vc_rr_arb3.sv
// rtl/vc_rr_arb3.sv - 3-way round-robin arbiter; grant depends only on req and pointer,
// pointer moves past the winner when en is high
module vc_rr_arb3
  import vc_crossbar_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic       en,
  output logic [2:0] gnt
);

  logic [1:0] ptr_q, ptr_d;
  logic [1:0] win;
  logic       found;

  always_comb begin
    gnt   = 3'b000;
    found = 1'b0;
    win   = ptr_q;
    for (int i = 0; i < c_nports; i++) begin
      if (!found && req[(int'(ptr_q) + i) % c_nports]) begin
        found = 1'b1;
        win   = 2'((int'(ptr_q) + i) % c_nports);
      end
    end
    if (found) gnt[win] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (en && found) ptr_d = next_port(win);
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= 2'd0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/vc_crossbar3_router.sv
// rtl/vc_crossbar3_router.sv - 3x3 self-arbitrating val/rdy router with one-entry output buffers.
// Optional VC_CROSSBAR3_ROUTER_DOMAIN_EN adds per-input domain tags and per-domain arbiter pointers.
module vc_crossbar3_router
  import vc_crossbar_pkg::*;
#(
  parameter int p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
`ifdef VC_CROSSBAR3_ROUTER_DOMAIN_EN
  input  logic               cur_sd,
  input  logic               in0_sd,
  input  logic               in1_sd,
  input  logic               in2_sd,
`endif
  input  logic [p_nbits-1:0] in0_msg,
  input  logic [1:0]         in0_dest,
  input  logic               in0_val,
  output logic               in0_rdy,
  input  logic [p_nbits-1:0] in1_msg,
  input  logic [1:0]         in1_dest,
  input  logic               in1_val,
  output logic               in1_rdy,
  input  logic [p_nbits-1:0] in2_msg,
  input  logic [1:0]         in2_dest,
  input  logic               in2_val,
  output logic               in2_rdy,
  output logic [p_nbits-1:0] out0_msg,
  output logic               out0_val,
  input  logic               out0_rdy,
  output logic [p_nbits-1:0] out1_msg,
  output logic               out1_val,
  input  logic               out1_rdy,
  output logic [p_nbits-1:0] out2_msg,
  output logic               out2_val,
  input  logic               out2_rdy
);

  logic [p_nbits-1:0] in_msg [c_nports];
  dest_t              in_dest [c_nports];
  logic [2:0]         in_val, in_ok, in_rdy, out_rdy;
  logic [2:0][2:0]    req, gnt;
  logic [2:0]         accept, xfer;
  logic [2:0]         out_val_q, out_val_d;
  logic [p_nbits-1:0] out_msg_q [c_nports];
  logic [p_nbits-1:0] out_msg_d [c_nports];

  assign in_msg[0]  = in0_msg;
  assign in_msg[1]  = in1_msg;
  assign in_msg[2]  = in2_msg;
  assign in_dest[0] = in0_dest;
  assign in_dest[1] = in1_dest;
  assign in_dest[2] = in2_dest;
  assign in_val     = {in2_val, in1_val, in0_val};
  assign out_rdy    = {out2_rdy, out1_rdy, out0_rdy};

`ifdef VC_CROSSBAR3_ROUTER_DOMAIN_EN
  assign in_ok = {in2_sd == cur_sd, in1_sd == cur_sd, in0_sd == cur_sd};
`else
  assign in_ok = 3'b111;
`endif

  always_comb begin
    req = '0;
    for (int j = 0; j < c_nports; j++) begin
      for (int k = 0; k < c_nports; k++) begin
        req[j][k] = in_val[k] && in_ok[k] && (in_dest[k] == 2'(j));
      end
    end
  end

  for (genvar j = 0; j < c_nports; j++) begin : g_arb
`ifdef VC_CROSSBAR3_ROUTER_DOMAIN_EN
    // Only the active domain's arbiter sees requests or advances, so the idle one keeps its order.
    logic [2:0] gnt_sd0, gnt_sd1;
    vc_rr_arb3 u_arb_sd0 (
      .clk   (clk),
      .reset (reset),
      .req   (cur_sd ? 3'b000 : req[j]),
      .en    (!cur_sd && xfer[j]),
      .gnt   (gnt_sd0)
    );
    vc_rr_arb3 u_arb_sd1 (
      .clk   (clk),
      .reset (reset),
      .req   (cur_sd ? req[j] : 3'b000),
      .en    (cur_sd && xfer[j]),
      .gnt   (gnt_sd1)
    );
    assign gnt[j] = cur_sd ? gnt_sd1 : gnt_sd0;
`else
    vc_rr_arb3 u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (req[j]),
      .en    (xfer[j]),
      .gnt   (gnt[j])
    );
`endif
  end

  always_comb begin
    accept = '0;
    xfer   = '0;
    for (int j = 0; j < c_nports; j++) begin
      accept[j] = !out_val_q[j] || out_rdy[j];
      xfer[j]   = (|gnt[j]) && accept[j];
    end
  end

  // out_rdy reaches in_rdy combinationally through accept; upstream must not loop it back.
  always_comb begin
    in_rdy = '0;
    for (int k = 0; k < c_nports; k++) begin
      if (!reset && in_val[k] && in_ok[k]) begin
        if (in_dest[k] == c_dest_drop) begin
          in_rdy[k] = 1'b1;
        end else begin
          for (int j = 0; j < c_nports; j++) begin
            if (in_dest[k] == 2'(j)) in_rdy[k] = gnt[j][k] && accept[j];
          end
        end
      end
    end
  end

  assign in0_rdy = in_rdy[0];
  assign in1_rdy = in_rdy[1];
  assign in2_rdy = in_rdy[2];

  always_comb begin
    out_val_d = out_val_q;
    for (int j = 0; j < c_nports; j++) begin
      out_msg_d[j] = out_msg_q[j];
      if (xfer[j]) begin
        out_val_d[j] = 1'b1;
        for (int k = 0; k < c_nports; k++) begin
          if (gnt[j][k]) out_msg_d[j] = in_msg[k];
        end
      end else if (out_rdy[j]) begin
        out_val_d[j] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) out_val_q <= 3'b000;
    else       out_val_q <= out_val_d;
  end

  always_ff @(posedge clk) begin
    out_msg_q <= out_msg_d;
  end

  assign out0_msg = out_msg_q[0];
  assign out1_msg = out_msg_q[1];
  assign out2_msg = out_msg_q[2];
  assign out0_val = out_val_q[0];
  assign out1_val = out_val_q[1];
  assign out2_val = out_val_q[2];

endmodule

// File: tb/tb_vc_crossbar3_router.sv
// tb/tb_vc_crossbar3_router.sv - bench for vc_crossbar3_router: directed table, hand sequences, random vs model
module tb_vc_crossbar3_router;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [2:0]  ival, ordy;
  logic [1:0]  idest [3];
  logic [31:0] imsg [3];
  logic [31:0] in0_msg, in1_msg, in2_msg, out0_msg, out1_msg, out2_msg;
  logic [1:0]  in0_dest, in1_dest, in2_dest;
  logic        in0_rdy, in1_rdy, in2_rdy, out0_val, out1_val, out2_val;
  logic [2:0]  irdy, oval;
  logic [31:0] omsg [3];
`ifdef VC_CROSSBAR3_ROUTER_DOMAIN_EN
  logic        cur_sd;
  logic [2:0]  isd;
`endif

  assign in0_msg  = imsg[0];
  assign in1_msg  = imsg[1];
  assign in2_msg  = imsg[2];
  assign in0_dest = idest[0];
  assign in1_dest = idest[1];
  assign in2_dest = idest[2];
  assign irdy     = {in2_rdy, in1_rdy, in0_rdy};
  assign oval     = {out2_val, out1_val, out0_val};
  assign omsg[0]  = out0_msg;
  assign omsg[1]  = out1_msg;
  assign omsg[2]  = out2_msg;

  vc_crossbar3_router #(.p_nbits(32)) dut (
    .clk      (clk),
    .reset    (reset),
`ifdef VC_CROSSBAR3_ROUTER_DOMAIN_EN
    .cur_sd   (cur_sd),
    .in0_sd   (isd[0]),
    .in1_sd   (isd[1]),
    .in2_sd   (isd[2]),
`endif
    .in0_msg  (in0_msg),
    .in0_dest (in0_dest),
    .in0_val  (ival[0]),
    .in0_rdy  (in0_rdy),
    .in1_msg  (in1_msg),
    .in1_dest (in1_dest),
    .in1_val  (ival[1]),
    .in1_rdy  (in1_rdy),
    .in2_msg  (in2_msg),
    .in2_dest (in2_dest),
    .in2_val  (ival[2]),
    .in2_rdy  (in2_rdy),
    .out0_msg (out0_msg),
    .out0_val (out0_val),
    .out0_rdy (ordy[0]),
    .out1_msg (out1_msg),
    .out1_val (out1_val),
    .out1_rdy (ordy[1]),
    .out2_msg (out2_msg),
    .out2_val (out2_val),
    .out2_rdy (ordy[2])
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // one row = one cycle; expectations are sampled before that cycle's edge
  typedef struct packed {
    logic        rst;
    logic [2:0]  val;
    logic [5:0]  dest;
    logic [23:0] msg;
    logic [2:0]  ordy;
    logic [2:0]  e_rdy;
    logic [2:0]  e_oval;
    logic [23:0] e_omsg;
  } vec_t;

  vec_t tbl [25];

  // reference model state
  bit          mval [3];
  logic [31:0] mmsg [3];
  int          mptr [3];

  initial begin
    tbl[0]  = {1'b1, 3'b111, 6'b01_01_01, 24'h121110, 3'b000, 3'b000, 3'b000, 24'h000000};
    tbl[1]  = {1'b0, 3'b001, 6'b00_00_10, 24'h0000A5, 3'b000, 3'b001, 3'b000, 24'h000000};
    tbl[2]  = {1'b0, 3'b000, 6'b00_00_00, 24'h000000, 3'b000, 3'b000, 3'b100, 24'hA50000};
    tbl[3]  = {1'b0, 3'b000, 6'b00_00_00, 24'h000000, 3'b100, 3'b000, 3'b100, 24'hA50000};
    tbl[4]  = {1'b0, 3'b000, 6'b00_00_00, 24'h000000, 3'b000, 3'b000, 3'b000, 24'h000000};
    tbl[5]  = {1'b0, 3'b111, 6'b01_01_01, 24'h121110, 3'b010, 3'b001, 3'b000, 24'h000000};
    tbl[6]  = {1'b0, 3'b111, 6'b01_01_01, 24'h121110, 3'b010, 3'b010, 3'b010, 24'h001000};
    tbl[7]  = {1'b0, 3'b111, 6'b01_01_01, 24'h121110, 3'b010, 3'b100, 3'b010, 24'h001100};
    tbl[8]  = {1'b0, 3'b111, 6'b01_01_01, 24'h121110, 3'b010, 3'b001, 3'b010, 24'h001200};
    tbl[9]  = {1'b0, 3'b000, 6'b00_00_00, 24'h000000, 3'b010, 3'b000, 3'b010, 24'h001000};
    tbl[10] = {1'b1, 3'b000, 6'b00_00_00, 24'h000000, 3'b000, 3'b000, 3'b000, 24'h000000};
    tbl[11] = {1'b0, 3'b100, 6'b01_00_00, 24'h200000, 3'b000, 3'b100, 3'b000, 24'h000000};
    tbl[12] = {1'b0, 3'b101, 6'b01_00_01, 24'h320030, 3'b000, 3'b000, 3'b010, 24'h002000};
    tbl[13] = {1'b0, 3'b101, 6'b01_00_01, 24'h320030, 3'b000, 3'b000, 3'b010, 24'h002000};
    tbl[14] = {1'b0, 3'b101, 6'b01_00_01, 24'h320030, 3'b010, 3'b001, 3'b010, 24'h002000};
    tbl[15] = {1'b0, 3'b100, 6'b01_00_00, 24'h320000, 3'b010, 3'b100, 3'b010, 24'h003000};
    tbl[16] = {1'b0, 3'b000, 6'b00_00_00, 24'h000000, 3'b010, 3'b000, 3'b010, 24'h003200};
    tbl[17] = {1'b0, 3'b111, 6'b00_10_01, 24'h030201, 3'b000, 3'b111, 3'b000, 24'h000000};
    tbl[18] = {1'b0, 3'b000, 6'b00_00_00, 24'h000000, 3'b000, 3'b000, 3'b111, 24'h020103};
    tbl[19] = {1'b0, 3'b010, 6'b00_11_00, 24'h007700, 3'b000, 3'b010, 3'b111, 24'h020103};
    tbl[20] = {1'b0, 3'b000, 6'b00_00_00, 24'h000000, 3'b000, 3'b000, 3'b111, 24'h020103};
    tbl[21] = {1'b1, 3'b000, 6'b00_00_00, 24'h000000, 3'b000, 3'b000, 3'b111, 24'h020103};
    tbl[22] = {1'b0, 3'b000, 6'b00_00_00, 24'h000000, 3'b000, 3'b000, 3'b000, 24'h000000};
    tbl[23] = {1'b0, 3'b111, 6'b01_01_01, 24'h424140, 3'b000, 3'b001, 3'b000, 24'h000000};
    tbl[24] = {1'b0, 3'b000, 6'b00_00_00, 24'h000000, 3'b000, 3'b000, 3'b010, 24'h004000};

    reset = 1'b1;
    ival  = 3'b000;
    ordy  = 3'b000;
    for (int k = 0; k < 3; k++) begin
      idest[k] = 2'd0;
      imsg[k]  = 32'h0;
    end
`ifdef VC_CROSSBAR3_ROUTER_DOMAIN_EN
    cur_sd = 1'b0;
    isd    = 3'b000;
`endif
    @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < 25; i++) begin
      reset = tbl[i].rst;
      ival  = tbl[i].val;
      ordy  = tbl[i].ordy;
      for (int k = 0; k < 3; k++) begin
        idest[k] = tbl[i].dest[2*k +: 2];
        imsg[k]  = {24'h0, tbl[i].msg[8*k +: 8]};
      end
      #1;
      chk($sformatf("row%0d in_rdy", i), {29'h0, irdy}, {29'h0, tbl[i].e_rdy});
      chk($sformatf("row%0d out_val", i), {29'h0, oval}, {29'h0, tbl[i].e_oval});
      for (int j = 0; j < 3; j++) begin
        if (tbl[i].e_oval[j])
          chk($sformatf("row%0d out%0d_msg", i, j), omsg[j], {24'h0, tbl[i].e_omsg[8*j +: 8]});
      end
      @(posedge clk);
      @(negedge clk);
    end

    // back-to-back streaming through one port: one message per cycle, one cycle latency
    reset = 1'b0;
    ival  = 3'b001;
    ordy  = 3'b001;
    idest[0] = 2'd0;
    for (int c = 0; c < 5; c++) begin
      imsg[0] = 32'hB0 + c;
      #1;
      chk($sformatf("stream%0d in0_rdy", c), {31'h0, in0_rdy}, 32'h1);
      chk($sformatf("stream%0d out0_val", c), {31'h0, out0_val}, (c == 0) ? 32'h0 : 32'h1);
      if (c > 0) chk($sformatf("stream%0d out0_msg", c), out0_msg, 32'hB0 + c - 1);
      @(posedge clk);
      @(negedge clk);
    end

`ifdef VC_CROSSBAR3_ROUTER_DOMAIN_EN
    reset = 1'b1;
    ival  = 3'b000;
    ordy  = 3'b000;
    next_cycle();
    reset    = 1'b0;
    cur_sd   = 1'b0;
    isd      = 3'b001;
    ival     = 3'b011;
    idest[0] = 2'd0;
    idest[1] = 2'd0;
    imsg[0]  = 32'hD0;
    imsg[1]  = 32'hD1;
    #1;
    chk("dom sd0 in_rdy", {29'h0, irdy}, 32'h2);
    next_cycle();
    chk("dom sd0 out0_msg", out0_msg, 32'hD1);
    ival   = 3'b001;
    cur_sd = 1'b1;
    ordy   = 3'b001;
    #1;
    chk("dom sd1 in_rdy", {29'h0, irdy}, 32'h1);
    next_cycle();
    chk("dom sd1 out0_msg", out0_msg, 32'hD0);
    idest[0] = 2'd3;
    cur_sd   = 1'b0;
    #1;
    chk("dom drop mismatched", {31'h0, in0_rdy}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    cur_sd = 1'b0;
    isd    = 3'b000;
`endif

    // randomized traffic against a rule-level model
    reset = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      int       win [3];
      bit       acc [3];
      logic [2:0] e_rdy;
      if (n > 0) reset = ($urandom_range(0, 63) == 0);
      for (int k = 0; k < 3; k++) begin
        ival[k]  = ($urandom_range(0, 3) != 0);
        idest[k] = 2'($urandom_range(0, 3));
        imsg[k]  = $urandom;
      end
      ordy = 3'($urandom_range(0, 7));
      #1;
      e_rdy = 3'b000;
      for (int j = 0; j < 3; j++) begin
        win[j] = -1;
        for (int i = 0; i < 3; i++) begin
          int k;
          k = (mptr[j] + i) % 3;
          if (win[j] < 0 && ival[k] && int'(idest[k]) == j) win[j] = k;
        end
        acc[j] = !mval[j] || ordy[j];
      end
      for (int k = 0; k < 3; k++) begin
        if (!reset && ival[k]) begin
          if (idest[k] == 2'd3) e_rdy[k] = 1'b1;
          else e_rdy[k] = (win[idest[k]] == k) && acc[idest[k]];
        end
      end
      if (n > 0) begin
        chk($sformatf("rand%0d in_rdy", n), {29'h0, irdy}, {29'h0, e_rdy});
        for (int j = 0; j < 3; j++) begin
          chk($sformatf("rand%0d out%0d_val", n, j), {31'h0, oval[j]}, {31'h0, mval[j]});
          if (mval[j]) chk($sformatf("rand%0d out%0d_msg", n, j), omsg[j], mmsg[j]);
        end
      end
      for (int j = 0; j < 3; j++) begin
        if (reset) begin
          mval[j] = 1'b0;
          mptr[j] = 0;
        end else if (win[j] >= 0 && acc[j]) begin
          mval[j] = 1'b1;
          mmsg[j] = imsg[win[j]];
          mptr[j] = (win[j] + 1) % 3;
        end else if (ordy[j]) begin
          mval[j] = 1'b0;
        end
      end
      @(posedge clk);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
